// File: rtl/fetch_decode.sv
// Instruction fetch and field decode stage: issues one imem read at a time and
// presents the decoded instruction word until the execute stage accepts it.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] constant,
  output logic [31:0] pc_out,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        discard_q, discard_d;
  logic        started_q, started_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      discard_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      discard_q <= discard_d;
      started_q <= started_d;
    end
  end

  // started_q keeps the first request off until one edge after reset release,
  // so a stale response landing in that gap meets an idle FETCH and is ignored.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    discard_d = discard_q;
    started_d = 1'b1;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (started_q) begin
          state_d = WAIT;
          if (redirect_valid) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (discard_q || redirect_valid) begin
            state_d = FETCH;
          end else begin
            instr_d = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (dec_ready) begin
          retired_d = retired_q + 32'd1;
          pc_d      = pc_q + 32'(PC_STEP);
          state_d   = FETCH;
        end
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == FETCH) && started_q;
    imem_addr = pc_q;
    dec_valid = (state_q == HOLD);
  end

  assign opcode   = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign shamt    = instr_q[10:6];
  assign funct    = instr_q[5:0];
  assign constant = instr_q[15:0];
  assign pc_out   = pc_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with hand-computed expected values.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] constant;
  logic [31:0] pc_out;
  logic [31:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fetch_decode #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .constant      (constant),
    .pc_out        (pc_out),
    .retired       (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    #3;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_dvalid", 32'(dec_valid), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    step(); step();
    check("rst_req_held", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    check("rel_req_before_edge", 32'(imem_req), 32'd0);
    step();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'd0);
    step();
    check("wait_req", 32'(imem_req), 32'd0);
    check("wait_dvalid", 32'(dec_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0023_0820;
    step();
    imem_rvalid = 1'b0;
    check("dec_valid", 32'(dec_valid), 32'd1);
    check("opcode", 32'(opcode), 32'd0);
    check("rs", 32'(rs), 32'd1);
    check("rt", 32'(rt), 32'd3);
    check("rd", 32'(rd), 32'd1);
    check("shamt", 32'(shamt), 32'd0);
    check("funct", 32'(funct), 32'h20);
    check("constant", 32'(constant), 32'h0820);
    check("pc_out", pc_out, 32'd0);
    check("hold_req", 32'(imem_req), 32'd0);

    // Stall 5 cycles; a stray rvalid during HOLD must not disturb the word.
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = (i == 2); imem_rdata = 32'hFFFF_FFFF;
      step();
      check("stall_dvalid", 32'(dec_valid), 32'd1);
      check("stall_const", 32'(constant), 32'h0820);
      check("stall_rs", 32'(rs), 32'd1);
      check("stall_retired", retired, 32'd0);
    end
    imem_rvalid = 1'b0;
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("next_req", 32'(imem_req), 32'd1);
    check("next_addr", imem_addr, 32'd4);
    check("retired1", retired, 32'd1);
    check("after_hs_dvalid", 32'(dec_valid), 32'd0);

    // Redirect while waiting; late response must be dropped.
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("redir_wait_dvalid", 32'(dec_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("drop_dvalid", 32'(dec_valid), 32'd0);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, 32'h100);
    check("drop_retired", retired, 32'd1);

    // Redirect issued in FETCH to pc 8; its own response is discarded.
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check("fetch_redir_dvalid", 32'(dec_valid), 32'd0);
    check("fetch_redir_addr", imem_addr, 32'h8);
    check("fetch_redir_req", 32'(imem_req), 32'd1);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h8C41_0004;
    step();
    imem_rvalid = 1'b0;
    check("lw_dvalid", 32'(dec_valid), 32'd1);
    check("lw_pc", pc_out, 32'h8);
    check("lw_opcode", 32'(opcode), 32'h23);
    check("lw_rs", 32'(rs), 32'd2);
    check("lw_rt", 32'(rt), 32'd1);
    check("lw_const", 32'(constant), 32'h0004);
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    dec_ready = 1'b0; redirect_valid = 1'b0;
    check("hs_redir_retired", retired, 32'd2);
    check("hs_redir_addr", imem_addr, 32'h40);
    check("hs_redir_req", 32'(imem_req), 32'd1);

    // Redirect in HOLD without handshake.
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0000;
    step();
    imem_rvalid = 1'b0;
    check("hold2_dvalid", 32'(dec_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("noready_dvalid", 32'(dec_valid), 32'd0);
    check("noready_retired", retired, 32'd2);
    check("noready_addr", imem_addr, 32'h80);

    // Redirect with same-cycle rvalid: no discard left pending.
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hC0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_AAAA;
    step();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    check("same_cyc_dvalid", 32'(dec_valid), 32'd0);
    check("same_cyc_addr", imem_addr, 32'hC0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    check("same_cyc_hold", 32'(dec_valid), 32'd1);
    check("same_cyc_funct", 32'(funct), 32'h38);
    check("same_cyc_shamt", 32'(shamt), 32'h19);
    check("same_cyc_pc", pc_out, 32'hC0);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("retired3", retired, 32'd3);
    check("pc_c4", imem_addr, 32'hC4);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    check("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0000;
    step();
    imem_rvalid = 1'b0;
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_retired", retired, 32'd4);

    // Asynchronous reset while holding an instruction.
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0023_0820;
    step();
    imem_rvalid = 1'b0;
    check("pre_rst_dvalid", 32'(dec_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_dvalid", 32'(dec_valid), 32'd0);
    check("async_retired", retired, 32'd0);
    check("async_req", 32'(imem_req), 32'd0);
    check("async_const", 32'(constant), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_addr", imem_addr, 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);

    // Reset mid-WAIT followed by a late response before the first request.
    step();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("late_req", 32'(imem_req), 32'd1);
    check("late_dvalid", 32'(dec_valid), 32'd0);
    check("late_addr", imem_addr, 32'd0);
    step();
    check("late_wait_dvalid", 32'(dec_valid), 32'd0);
    check("late_instr", 32'(constant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, PC increment per consumed instruction.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-006 imem_addr  output  32  read address, valid while imem_req=1.
REQ-007 imem_rvalid  input  1  read-data-valid strobe from instruction memory.
REQ-008 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-009 redirect_valid  input  1  branch/jump taken; PC replaced by redirect_pc.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 dec_valid  output  1  decoded fields below are valid.
REQ-012 dec_ready  input  1  execute stage (ALU) accepts the decoded instruction.
REQ-013 opcode  output  6  instr[31:26]; rs output 5 instr[25:21]; rt output 5 instr[20:16].
REQ-014 rd  output  5  instr[15:11]; shamt output 5 instr[10:6]; funct output 6 instr[5:0].
REQ-015 constant  output  16  instr[15:0], unextended immediate for the ALU.
REQ-016 pc_out  output  32  address of the instruction currently presented.
REQ-017 retired  output  32  count of completed dec_valid/dec_ready handshakes.

Function
REQ-018 FSM states SHALL be FETCH, WAIT, HOLD; reset state FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=pc (combinational from state), next state WAIT.
REQ-020 WAIT: on imem_rvalid=1, instr register <= imem_rdata, next HOLD; else stay WAIT.
REQ-021 HOLD: dec_valid=1; on dec_ready=1, pc <= pc+PC_STEP (32-bit wrap), retired+1, next FETCH.
REQ-022 All decoded outputs SHALL be driven from the instr register and be stable throughout HOLD.
REQ-023 At most one imem request outstanding; imem_req never asserted in WAIT or HOLD.
REQ-024 imem_rvalid in FETCH or HOLD SHALL be ignored with no state change.
REQ-025 Redirect in FETCH: pc <= redirect_pc, discard flag set, next WAIT; the response is dropped.
REQ-026 Redirect in WAIT (with or without same-cycle rvalid): pc <= redirect_pc, discard set unless rvalid arrives that cycle, next FETCH only once the in-flight response has returned.
REQ-027 WAIT with discard=1: rvalid clears discard, data dropped, next FETCH; dec_valid stays 0.
REQ-028 Redirect in HOLD without dec_ready: dec_valid drops next cycle, pc <= redirect_pc, next FETCH, retired unchanged.
REQ-029 Redirect in HOLD with dec_ready same cycle: handshake completes (retired+1), pc <= redirect_pc (not pc+PC_STEP), next FETCH.
REQ-030 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 Minimum latency request-to-dec_valid: 1 cycle after rvalid; peak throughput 1 instruction per 3 cycles.

Reset
REQ-032 rst_n=0 SHALL immediately force state FETCH, pc=RESET_PC, discard=0, instr=0, retired=0, dec_valid=0.
REQ-033 imem_req SHALL be 0 while rst_n=0 and assert on the first clock edge after release.
REQ-034 Reset mid-WAIT: late imem_rvalid after release arriving before the first request SHALL be ignored.

Verification
REQ-035 Release reset, rvalid one cycle after req with 32'h0023_0820 -> dec_valid=1, opcode=0, rs=1, rt=3, rd=1, shamt=0, funct=6'h20, constant=16'h0820, pc_out=0.
REQ-036 Hold dec_ready=0 for 5 cycles then 1 -> outputs stable 5 cycles, next imem_addr=4, retired=1.
REQ-037 redirect_valid=1, redirect_pc=32'h100 in WAIT, rvalid next cycle with 32'hDEAD_BEEF -> word dropped, next imem_addr=32'h100, dec_valid never 1 for it.
REQ-038 In HOLD at pc=8, dec_ready=1 with redirect_pc=32'h40 -> retired increments, next imem_addr=32'h40.
REQ-039 Assert rst_n=0 in HOLD -> dec_valid=0 asynchronously; after release imem_addr=RESET_PC, retired=0.
REQ-040 Preload pc=32'hFFFF_FFFC via redirect, consume one instruction -> next imem_addr=32'h0 (wrap).
